// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA job sequencer.
// Holds the datapath width, the FSM states and the timeout-limit helper.
package rsa_pkg;

    localparam int W = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        OUT
    } state_t;

    // 2*key + margin at W+2 bits, wide enough that it never overflows
    function automatic logic [W+1:0] to_limit(
        input logic [W-1:0] key,
        input int           margin
    );
        return {1'b0, key, 1'b0} + (W+2)'(margin);
    endfunction

endpackage

// File: rtl/rsa_in_fifo.sv
// Small synchronous FIFO that buffers input words ahead of the job FSM.
// Pointers wrap modulo DEPTH; a separate count tracks occupancy.
module rsa_in_fifo #(
    parameter int DW    = 6,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rsa_job_ctrl.sv
// Job sequencer for the RSA exponentiation core: queues input words,
// runs one core job per word under a watchdog and returns the results.
module rsa_job_ctrl
    import rsa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_MARGIN  = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_key,
    input  logic [W-1:0] cfg_n,
    output logic         cfg_busy,
    output logic         cfg_err,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         out_range,
    input  logic         out_ready,
    output logic         core_reset,
    output logic [W-1:0] core_data,
    output logic [W-1:0] core_key,
    output logic [W-1:0] core_n,
    input  logic [W-1:0] core_result,
    input  logic         core_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t         state;
    logic [W-1:0]   key_q;
    logic [W-1:0]   n_q;
    logic           range_q;
    logic [W+1:0]   wd;
    logic [W+1:0]   wd_inc;
    logic [W+1:0]   limit;
    logic           done_ok;
    logic           timeout;
    logic           cfg_accept;
    logic           push;
    logic           pop;
    logic [W-1:0]   fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;

    assign in_ready = (fifo_count < (AW+1)'(FIFO_DEPTH));
    assign push     = in_valid && !fifo_full;
    assign pop      = (state == IDLE) && !fifo_empty && !cfg_err;

    // Words stalled behind a bad config never use it, so it may be reloaded
    assign cfg_busy   = (state != IDLE) || (!fifo_empty && !cfg_err);
    assign cfg_accept = cfg_load && !cfg_busy;

    assign wd_inc  = (&wd) ? wd : wd + 1'b1;
    assign limit   = to_limit(core_key, TO_MARGIN);
    assign done_ok = core_done && (wd != '0);
    assign timeout = (wd_inc >= limit);

    rsa_in_fifo #(
        .DW    (W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            n_q     <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_accept) begin
            key_q   <= cfg_key;
            n_q     <= cfg_n;
            cfg_err <= (cfg_n < W'(2));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            core_data  <= '0;
            core_key   <= '0;
            core_n     <= '0;
            range_q    <= 1'b0;
            wd         <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            out_range  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        core_data <= fifo_dout;
                        core_key  <= key_q;
                        core_n    <= n_q;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    range_q    <= (core_data >= core_n);
                    wd         <= '0;
                    core_reset <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    wd <= wd_inc;
                    // A late Done still beats a simultaneous timeout
                    if (done_ok) begin
                        out_data   <= core_result;
                        out_err    <= 1'b0;
                        out_range  <= range_q;
                        out_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= OUT;
                    end else if (timeout) begin
                        out_data   <= '0;
                        out_err    <= 1'b1;
                        out_range  <= range_q;
                        out_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Directed bench for rsa_job_ctrl with a behavioural core stub
// and a result scoreboard.
module tb_rsa_job_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [5:0] cfg_key;
    logic [5:0] cfg_n;
    logic       cfg_busy;
    logic       cfg_err;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_data;
    logic       out_err;
    logic       out_range;
    logic       out_ready;
    logic       core_reset;
    logic [5:0] core_data;
    logic [5:0] core_key;
    logic [5:0] core_n;
    logic [5:0] core_result = '0;
    logic       core_done = 1'b0;

    typedef struct {
        int d;
        int e;
        int r;
        int k;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   jobs_started = 0;
    int   hang_until = 0;
    int   stub_cnt = 0;
    bit   stub_hang = 0;
    int   run_cnt = 0;
    int   last_run = 0;

    logic [5:0] hw [4] = '{6'd1, 6'd2, 6'd3, 6'd10};
    int         he [4] = '{1, 29, 9, 10};

    always #5 clk = ~clk;

    rsa_job_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_key     (cfg_key),
        .cfg_n       (cfg_n),
        .cfg_busy    (cfg_busy),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_range   (out_range),
        .out_ready   (out_ready),
        .core_reset  (core_reset),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_n      (core_n),
        .core_result (core_result),
        .core_done   (core_done)
    );

    function automatic int modexp(input int b, input int e, input int n);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Core stub: Done after a key-dependent latency unless told to hang
    always @(posedge clk) begin
        if (core_reset) begin
            stub_cnt  <= 0;
            core_done <= 1'b0;
        end else begin
            if (stub_cnt == 0) begin
                stub_hang    <= (jobs_started < hang_until);
                jobs_started <= jobs_started + 1;
            end
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == (int'(core_key) % 5) + 2 && !stub_hang) begin
                core_done   <= 1'b1;
                core_result <= 6'(modexp(int'(core_data), int'(core_key),
                                         int'(core_n)));
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (!core_reset) begin
                run_cnt++;
            end else begin
                if (run_cnt != 0) last_run = run_cnt;
                run_cnt = 0;
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), e.d);
                    chk("out_err", 32'(out_err), e.e);
                    chk("out_range", 32'(out_range), e.r);
                    if (e.e != 0) chk("run_len", last_run, 2 * e.k + 16);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int k, input int n);
        int c = 0;
        while (cfg_busy && c < 300) begin
            tick();
            c++;
        end
        chk("cfg_idle", 32'(cfg_busy), 0);
        cfg_load = 1'b1;
        cfg_key  = 6'(k);
        cfg_n    = 6'(n);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic push_word(input int w, input int ed, input int ee,
                             input int er, input int k, input int budget);
        int c = 0;
        in_valid = 1'b1;
        in_data  = 6'(w);
        @(negedge clk);
        while (!in_ready && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("push_ready", 32'(in_ready), 1);
        sb.push_back('{ed, ee, er, k});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        @(negedge clk);
        while ((sb.size() != 0 || cfg_busy) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("drain", sb.size(), 0);
        tick();
    endtask

    task automatic wait_run();
        int c = 0;
        while (core_reset && c < 20) begin
            tick();
            c++;
        end
        chk("job_started", 32'(core_reset), 0);
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_out_valid"}, 32'(out_valid), 0);
        chk({ph, "_out_data"}, 32'(out_data), 0);
        chk({ph, "_out_err"}, 32'(out_err), 0);
        chk({ph, "_out_range"}, 32'(out_range), 0);
        chk({ph, "_core_reset"}, 32'(core_reset), 1);
        chk({ph, "_core_data"}, 32'(core_data), 0);
        chk({ph, "_core_key"}, 32'(core_key), 0);
        chk({ph, "_core_n"}, 32'(core_n), 0);
        chk({ph, "_cfg_err"}, 32'(cfg_err), 0);
        chk({ph, "_cfg_busy"}, 32'(cfg_busy), 0);
        chk({ph, "_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int c;
        reset     = 1'b0;
        cfg_load  = 1'b0;
        cfg_key   = '0;
        cfg_n     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk_reset_vals("rst");
        reset = 1'b1;
        tick();

        // Encrypt two words with N=33, Key=7
        cfg(7, 33);
        push_word(4, 16, 0, 0, 7, 20);
        push_word(2, 29, 0, 0, 7, 20);
        wait_drain();

        // Decrypt round trip with Key=3
        cfg(3, 33);
        push_word(16, 4, 0, 0, 3, 20);
        wait_drain();

        // First job hangs and times out while the FIFO fills behind it
        cfg(7, 33);
        hang_until = jobs_started + 1;
        push_word(5, 0, 1, 0, 7, 20);
        wait_run();
        for (int i = 0; i < 4; i++) push_word(hw[i], he[i], 0, 0, 7, 20);
        @(negedge clk);
        chk("fill_full", 32'(in_ready), 0);
        push_word(40, 28, 0, 1, 7, 80);
        wait_drain();

        // Downstream stall: result held, FIFO keeps filling
        out_ready = 1'b0;
        push_word(4, 16, 0, 0, 7, 20);
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("hold_seen", 32'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = hw[0];
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 16);
            chk("hold_core", 32'(core_reset), 1);
            chk("hold_ready", 32'(in_ready), 32'(i < 4));
            if (i < 4) sb.push_back('{he[i], 0, 0, 7});
            @(posedge clk);
            #1;
            if (i + 1 < 4) in_data = hw[i+1];
            else in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_drain();

        // Bad modulus stalls the queue until a good config arrives
        cfg(7, 1);
        chk("cfg_err_set", 32'(cfg_err), 1);
        push_word(4, 16, 0, 0, 7, 20);
        repeat (8) tick();
        chk("stall_valid", 32'(out_valid), 0);
        chk("stall_core", 32'(core_reset), 1);
        cfg(7, 33);
        chk("cfg_err_clr", 32'(cfg_err), 0);
        wait_drain();

        // Asynchronous reset in the middle of a job
        in_valid = 1'b1;
        in_data  = 6'd9;
        tick();
        in_valid = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'd11;
        tick();
        in_valid = 1'b0;
        wait_run();
        tick();
        reset = 1'b0;
        #2;
        chk_reset_vals("midrst");
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        cfg(3, 33);
        push_word(16, 4, 0, 0, 3, 20);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
